// File: rtl/aes_enc_rr_arbiter.sv
// Round-robin front end that shares one AES encryption core between NUM_REQ requesters.
// One job in flight: grant, launch the core, wait for its result (or time out), hold the response.
module aes_enc_rr_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned ID_W         = 2,
    parameter int unsigned BLOCK_LENGTH = 128,
    parameter int unsigned KEY_LENGTH   = 128,
    parameter int unsigned TIMEOUT_CYC  = 64
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic [NUM_REQ-1:0]               Req_Valid,
    output logic [NUM_REQ-1:0]               Req_Ready,
    input  logic [NUM_REQ*BLOCK_LENGTH-1:0]  Req_PT,
    input  logic [NUM_REQ*KEY_LENGTH-1:0]    Req_KEY,
    output logic                             Rsp_Valid,
    input  logic                             Rsp_Ready,
    output logic [ID_W-1:0]                  Rsp_ID,
    output logic [BLOCK_LENGTH-1:0]          Rsp_CT,
    output logic                             Rsp_Err,
    output logic                             Core_En,
    output logic [BLOCK_LENGTH-1:0]          Core_PT,
    output logic [KEY_LENGTH-1:0]            Core_KEY,
    input  logic [BLOCK_LENGTH-1:0]          Core_CT,
    input  logic                             Core_Valid
);

    localparam int unsigned TMR_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    state_e                   state_q, state_d;
    logic [ID_W-1:0]          last_q, last_d;
    logic [ID_W-1:0]          rsp_id_q, rsp_id_d;
    logic [ID_W-1:0]          job_id_q, job_id_d;
    logic [BLOCK_LENGTH-1:0]  pt_q, pt_d;
    logic [KEY_LENGTH-1:0]    key_q, key_d;
    logic [BLOCK_LENGTH-1:0]  ct_q, ct_d;
    logic                     err_q, err_d;
    logic                     rsp_valid_q, rsp_valid_d;
    logic                     core_en_q, core_en_d;
    logic [TMR_W-1:0]         timer_q, timer_d;

    logic                     found_c;
    logic [ID_W-1:0]          winner_c;
    logic [ID_W-1:0]          cand_c;
    logic [BLOCK_LENGTH-1:0]  pt_sel_c;
    logic [KEY_LENGTH-1:0]    key_sel_c;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        found_c  = 1'b0;
        winner_c = '0;
        cand_c   = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand_c = ID_W'((32'(last_q) + k) % NUM_REQ);
            if (!found_c && Req_Valid[cand_c]) begin
                found_c  = 1'b1;
                winner_c = cand_c;
            end
        end
    end

    always_comb begin
        Req_Ready = '0;
        if (state_q == ST_IDLE && found_c) begin
            Req_Ready[winner_c] = 1'b1;
        end
    end

    always_comb begin
        pt_sel_c  = '0;
        key_sel_c = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (winner_c == ID_W'(i)) begin
                pt_sel_c  = Req_PT[i*BLOCK_LENGTH +: BLOCK_LENGTH];
                key_sel_c = Req_KEY[i*KEY_LENGTH +: KEY_LENGTH];
            end
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        rsp_id_d    = rsp_id_q;
        job_id_d    = job_id_q;
        pt_d        = pt_q;
        key_d       = key_q;
        ct_d        = ct_q;
        err_d       = err_q;
        rsp_valid_d = rsp_valid_q;
        core_en_d   = 1'b0;
        timer_d     = timer_q;
        unique case (state_q)
            ST_IDLE: begin
                if (found_c) begin
                    job_id_d  = winner_c;
                    last_d    = winner_c;
                    pt_d      = pt_sel_c;
                    key_d     = key_sel_c;
                    core_en_d = 1'b1;
                    state_d   = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                timer_d = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (Core_Valid) begin
                    ct_d        = Core_CT;
                    err_d       = 1'b0;
                    rsp_id_d    = job_id_q;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else if (timer_q == TMR_W'(TIMEOUT_CYC - 1)) begin
                    ct_d        = '0;
                    err_d       = 1'b1;
                    rsp_id_d    = job_id_q;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_RESP: begin
                if (Rsp_Ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Reset favours requester 0 on the first arbitration.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= ST_IDLE;
            last_q      <= ID_W'(NUM_REQ - 1);
            rsp_id_q    <= '0;
            job_id_q    <= '0;
            pt_q        <= '0;
            key_q       <= '0;
            ct_q        <= '0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            core_en_q   <= 1'b0;
            timer_q     <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            rsp_id_q    <= rsp_id_d;
            job_id_q    <= job_id_d;
            pt_q        <= pt_d;
            key_q       <= key_d;
            ct_q        <= ct_d;
            err_q       <= err_d;
            rsp_valid_q <= rsp_valid_d;
            core_en_q   <= core_en_d;
            timer_q     <= timer_d;
        end
    end

    assign Rsp_Valid = rsp_valid_q;
    assign Rsp_ID    = rsp_id_q;
    assign Rsp_CT    = ct_q;
    assign Rsp_Err   = err_q;
    assign Core_En   = core_en_q;
    assign Core_PT   = pt_q;
    assign Core_KEY  = key_q;

endmodule

// File: tb/tb_aes_enc_rr_arbiter.sv
// Scoreboard bench for aes_enc_rr_arbiter with a behavioural AES-128 core model.
// A monitor predicts grants and responses from round-robin rules and compares every cycle.
module tb_aes_enc_rr_arbiter;

    localparam int NR  = 4;
    localparam int IDW = 2;
    localparam int BL  = 128;
    localparam int KL  = 128;
    localparam int TO  = 64;

    localparam logic [KL-1:0] FIX_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [BL-1:0] FIX_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [BL-1:0] FIX_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic            CLK = 1'b0;
    logic            RST = 1'b0;
    logic [NR-1:0]   Req_Valid;
    logic [NR-1:0]   Req_Ready;
    logic [NR*BL-1:0] Req_PT;
    logic [NR*KL-1:0] Req_KEY;
    logic            Rsp_Valid;
    logic            Rsp_Ready;
    logic [IDW-1:0]  Rsp_ID;
    logic [BL-1:0]   Rsp_CT;
    logic            Rsp_Err;
    logic            Core_En;
    logic [BL-1:0]   Core_PT;
    logic [KL-1:0]   Core_KEY;
    logic [BL-1:0]   Core_CT;
    logic            Core_Valid;

    always #5 CLK = ~CLK;

    aes_enc_rr_arbiter #(
        .NUM_REQ(NR), .ID_W(IDW), .BLOCK_LENGTH(BL), .KEY_LENGTH(KL), .TIMEOUT_CYC(TO)
    ) dut (
        .CLK(CLK), .RST(RST),
        .Req_Valid(Req_Valid), .Req_Ready(Req_Ready), .Req_PT(Req_PT), .Req_KEY(Req_KEY),
        .Rsp_Valid(Rsp_Valid), .Rsp_Ready(Rsp_Ready), .Rsp_ID(Rsp_ID), .Rsp_CT(Rsp_CT),
        .Rsp_Err(Rsp_Err), .Core_En(Core_En), .Core_PT(Core_PT), .Core_KEY(Core_KEY),
        .Core_CT(Core_CT), .Core_Valid(Core_Valid)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // ---------------- AES-128 reference ----------------
    logic [7:0] sbox_t [256];

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rl(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b};
        return t[15-n -: 8];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_t[x] = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes128(input logic [127:0] pt, input logic [127:0] key);
        logic [31:0]  w [44];
        logic [31:0]  t;
        logic [7:0]   rc;
        logic [7:0]   s [16];
        logic [7:0]   n [16];
        logic [127:0] st;
        logic [7:0]   a0, a1, a2, a3;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        st = pt ^ {w[0], w[1], w[2], w[3]};
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox_t[st[127-8*i -: 8]];
            for (int c = 0; c < 4; c++)
                for (int q = 0; q < 4; q++) n[q+4*c] = s[q+4*((c+q)%4)];
            for (int c = 0; c < 4; c++) begin
                a0 = n[4*c]; a1 = n[4*c+1]; a2 = n[4*c+2]; a3 = n[4*c+3];
                if (r < 10) begin
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end else begin
                    s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
                end
            end
            for (int i = 0; i < 16; i++) st[127-8*i -: 8] = s[i];
            st = st ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
        return st;
    endfunction

    // ---------------- core model ----------------
    logic hang = 1'b0;
    int   core_lat = 3;
    int   spur_cnt = 0;

    initial begin
        int         cnt;
        logic       busy;
        logic       en;
        logic [BL-1:0] pend;
        int         spur_done;
        Core_Valid = 1'b0;
        Core_CT    = '0;
        busy = 1'b0; cnt = 0; spur_done = 0; pend = '0;
        forever begin
            @(negedge CLK);
            en = Core_En;
            if (en && !hang) pend = aes128(Core_PT, Core_KEY);
            @(posedge CLK);
            #1;
            Core_Valid = 1'b0;
            Core_CT    = '0;
            if (!RST) begin
                busy = 1'b0;
            end else if (spur_cnt != spur_done) begin
                spur_done  = spur_cnt;
                Core_Valid = 1'b1;
                Core_CT    = {4{32'hdeadbeef}};
            end else begin
                if (en && !hang) begin
                    cnt  = core_lat;
                    busy = 1'b1;
                end
                if (busy) begin
                    if (cnt <= 1) begin
                        Core_Valid = 1'b1;
                        Core_CT    = pend;
                        busy       = 1'b0;
                    end else begin
                        cnt--;
                    end
                end
            end
        end
    end

    // ---------------- reference model + monitor ----------------
    typedef struct {
        int            id;
        logic [BL-1:0] ct;
        logic          err;
        int            gcyc;
        int            lat;
    } exp_t;

    exp_t          sb[$];
    int            got_ids[$];
    logic [BL-1:0] last_ct = '0;
    logic          last_err = 1'b0;
    logic          mdl_busy = 1'b0;
    int            mdl_last = NR - 1;
    int            grant_cyc = -10;
    logic [BL-1:0] grant_pt = '0;
    logic [KL-1:0] grant_key = '0;
    logic          rsp_seen = 1'b0;
    int            cyc = 0;

    initial begin
        int          win;
        int          c;
        logic [NR-1:0] exp_rdy;
        logic        exp_en;
        exp_t        e;
        forever begin
            @(negedge CLK);
            cyc++;
            if (!RST) begin
                chk("reset_outputs", 256'(|{Req_Ready, Rsp_Valid, Rsp_ID, Rsp_CT, Rsp_Err,
                                           Core_En, Core_PT, Core_KEY}), '0);
                sb.delete();
                mdl_busy  = 1'b0;
                mdl_last  = NR - 1;
                rsp_seen  = 1'b0;
                grant_cyc = -10;
            end else begin
                exp_en = mdl_busy && (cyc == grant_cyc + 1);
                if (exp_en || Core_En) begin
                    chk("core_en", 256'(Core_En), 256'(exp_en));
                    if (exp_en) begin
                        chk("core_pt", 256'(Core_PT), 256'(grant_pt));
                        chk("core_key", 256'(Core_KEY), 256'(grant_key));
                    end
                end
                if (!mdl_busy) begin
                    exp_rdy = '0;
                    win = -1;
                    for (int k = 1; k <= NR; k++) begin
                        c = (mdl_last + k) % NR;
                        if (win < 0 && Req_Valid[c]) win = c;
                    end
                    if (win >= 0) exp_rdy[win] = 1'b1;
                    if (win >= 0 || Req_Ready != '0)
                        chk("req_ready", 256'(Req_Ready), 256'(exp_rdy));
                    if (win >= 0) begin
                        grant_pt  = Req_PT[win*BL +: BL];
                        grant_key = Req_KEY[win*KL +: KL];
                        e.id   = win;
                        e.err  = hang;
                        e.ct   = hang ? '0 : aes128(grant_pt, grant_key);
                        e.gcyc = cyc;
                        e.lat  = hang ? TO + 2 : core_lat + 2;
                        sb.push_back(e);
                        mdl_busy  = 1'b1;
                        mdl_last  = win;
                        grant_cyc = cyc;
                    end
                end else begin
                    chk("no_grant_busy", 256'(Req_Ready), '0);
                end
                if (Rsp_Valid) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_rsp", 256'(Rsp_Valid), '0);
                    end else begin
                        e = sb[0];
                        if (!rsp_seen) chk("rsp_latency", 256'(cyc - e.gcyc), 256'(e.lat));
                        rsp_seen = 1'b1;
                        chk("rsp_id", 256'(Rsp_ID), 256'(e.id));
                        chk("rsp_ct", 256'(Rsp_CT), 256'(e.ct));
                        chk("rsp_err", 256'(Rsp_Err), 256'(e.err));
                        if (Rsp_Ready) begin
                            void'(sb.pop_front());
                            got_ids.push_back(int'(Rsp_ID));
                            last_ct  = Rsp_CT;
                            last_err = Rsp_Err;
                            mdl_busy = 1'b0;
                            rsp_seen = 1'b0;
                        end
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    int   left [NR];
    logic same_data = 1'b1;
    logic rand_ready = 1'b0;
    logic hold = 1'b0;

    task automatic set_data(input int i);
        Req_PT[i*BL +: BL]  = same_data ? FIX_PT  : {$urandom, $urandom, $urandom, $urandom};
        Req_KEY[i*KL +: KL] = same_data ? FIX_KEY : {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic add_job(input int i, input int n);
        left[i] = n;
        Req_Valid[i] = 1'b1;
        set_data(i);
    endtask

    task automatic step();
        logic [NR-1:0] hs;
        @(negedge CLK);
        hs = Req_Valid & Req_Ready;
        @(posedge CLK);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (hs[i]) begin
                left[i]--;
                if (left[i] > 0) set_data(i);
                else Req_Valid[i] = 1'b0;
            end
        end
        Rsp_Ready = hold ? 1'b0 : (rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
    endtask

    task automatic wait_idle(input int maxc);
        int n;
        n = 0;
        while ((Req_Valid != '0 || mdl_busy || sb.size() != 0) && n < maxc) begin
            step();
            n++;
        end
        chk("drain_timeout", 256'(n >= maxc), '0);
    endtask

    task automatic chk_id(input int idx, input int expv);
        checks++;
        if (idx >= got_ids.size() || got_ids[idx] != expv) begin
            failures++;
            $display("FAIL grant_order[%0d]: got %0d expected %0d", idx,
                     (idx < got_ids.size()) ? got_ids[idx] : -1, expv);
        end
    endtask

    initial begin
        int base;
        int n;
        for (int i = 0; i < NR; i++) left[i] = 0;
        Req_Valid = '0;
        Req_PT    = '0;
        Req_KEY   = '0;
        Rsp_Ready = 1'b1;
        build_sbox();
        repeat (3) @(posedge CLK);
        #1 RST = 1'b1;

        // all requesters, same job: 0,1,2,3,0,1,2,3
        core_lat = 2;
        base = got_ids.size();
        for (int i = 0; i < NR; i++) add_job(i, 2);
        wait_idle(400);
        for (int j = 0; j < 8; j++) chk_id(base + j, j % NR);

        // single known-answer job on requester 0
        core_lat = 3;
        base = got_ids.size();
        add_job(0, 1);
        wait_idle(100);
        chk_id(base, 0);
        chk("kat_ct", 256'(last_ct), 256'(FIX_CT));
        chk("kat_err", 256'(last_err), '0);

        // response back-pressure: no new grant while the response is held
        same_data = 1'b0;
        core_lat = 4;
        hold = 1'b1;
        Rsp_Ready = 1'b0;
        base = got_ids.size();
        add_job(2, 1);
        n = 0;
        while (!Rsp_Valid && n < 60) begin step(); n++; end
        chk("hold_rsp_arrives", 256'(Rsp_Valid), 256'(1));
        add_job(1, 1);
        repeat (10) step();
        chk("hold_rsp_valid", 256'(Rsp_Valid), 256'(1));
        chk("hold_req1_pending", 256'(Req_Valid[1]), 256'(1));
        hold = 1'b0;
        wait_idle(100);
        chk_id(base, 2);
        chk_id(base + 1, 1);

        // watchdog abort
        hang = 1'b1;
        add_job(3, 1);
        wait_idle(200);
        hang = 1'b0;
        chk("timeout_err", 256'(last_err), 256'(1));
        chk("timeout_ct", 256'(last_ct), '0);

        // reset during WAIT followed by a stray core strobe
        hang = 1'b1;
        base = got_ids.size();
        add_job(0, 1);
        repeat (6) step();
        @(posedge CLK);
        #1 RST = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b1;
        hang = 1'b0;
        spur_cnt++;
        repeat (6) step();
        chk("post_reset_rsp_valid", 256'(Rsp_Valid), '0);
        chk("post_reset_no_rsp", 256'(got_ids.size() - base), '0);
        add_job(3, 1);
        add_job(1, 1);
        add_job(0, 1);
        wait_idle(200);
        chk_id(base, 0);
        chk_id(base + 1, 1);
        chk_id(base + 2, 3);

        // requester 2 withdraws before being granted
        core_lat = 6;
        base = got_ids.size();
        add_job(0, 1);
        step();
        add_job(1, 1);
        add_job(2, 1);
        add_job(3, 1);
        step();
        step();
        Req_Valid[2] = 1'b0;
        left[2] = 0;
        wait_idle(200);
        chk_id(base, 0);
        chk_id(base + 1, 1);
        chk_id(base + 2, 3);
        chk("withdrawn_count", 256'(got_ids.size() - base), 256'(3));

        // randomized traffic
        rand_ready = 1'b1;
        for (int b = 0; b < 10; b++) begin
            core_lat = $urandom_range(1, 8);
            for (int s = 0; s < 40; s++) begin
                int i;
                i = $urandom_range(0, NR - 1);
                if ($urandom_range(0, 2) == 0 && !Req_Valid[i]) add_job(i, $urandom_range(1, 3));
                step();
            end
            wait_idle(800);
        end
        rand_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global guard against a hung run.
    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "global timeout");
    end

endmodule
